// File: rtl/seq_detector_prog_if.sv
// Bus between a serial-stream source and the programmable pattern detector.
// The master modport drives the bit stream and configuration; the slave modport is the detector.
interface seq_detector_prog_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               y;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    modport master (
        output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  y, match_count, armed
    );

    modport slave (
        input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output y, match_count, armed
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-programmable Mealy serial pattern detector with input qualification,
// selectable overlap mode and a saturating match counter.
module seq_detector_prog #(
    parameter int unsigned        MAX_LEN       = 8,
    parameter int unsigned        CNT_W         = 16,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = 'b1011,
    parameter int unsigned        RESET_LEN     = 4,
    parameter bit                 RESET_OVERLAP = 1'b1
) (
    input logic               clk,
    input logic               reset,
    seq_detector_prog_if.slave bus
);
    localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1);
    localparam int unsigned HIST_W      = MAX_LEN - 1;
    localparam bit          RESET_ARMED = (RESET_LEN != 0) && (RESET_LEN <= MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               armed_q;
    logic [HIST_W-1:0]  hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;
    logic               pat_ok;
    logic               hit;

    always_comb begin
        cand = {hist_q, bus.x};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        // Only meaningful when armed, so len_q >= 1 and the subtraction cannot wrap.
        fill_ok = (fill_q >= (len_q - LEN_W'(1)));
        pat_ok  = (((cand ^ pat_q) & mask) == '0);
        hit     = bus.x_valid & ~bus.cfg_load & ~reset & armed_q & fill_ok & pat_ok;
    end

    assign bus.y           = hit;
    assign bus.match_count = cnt_q;
    assign bus.armed       = armed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= RESET_PATTERN;
            len_q   <= LEN_W'(RESET_LEN);
            ovl_q   <= RESET_OVERLAP;
            armed_q <= RESET_ARMED;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else if (bus.cfg_load) begin
            pat_q   <= bus.cfg_pattern;
            len_q   <= bus.cfg_len;
            ovl_q   <= bus.cfg_overlap;
            armed_q <= (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else if (bus.x_valid) begin
            // Non-overlapping mode restarts from an empty history after every match.
            if (hit && !ovl_q) begin
                hist_q <= '0;
                fill_q <= '0;
            end else begin
                hist_q <= cand[HIST_W-1:0];
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + LEN_W'(1);
                end
            end
            if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a 16-bit-counter and a 2-bit-counter instance
// share one stimulus stream; hand-computed expectations are checked with immediate assertions.
module tb_seq_detector_prog;
    logic       clk;
    logic       reset;
    logic       x;
    logic       x_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;

    int errors = 0;
    int checks = 0;

    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(16)) b1 ();
    seq_detector_prog_if #(.MAX_LEN(8), .CNT_W(2))  b2 ();

    assign b1.x = x;
    assign b1.x_valid = x_valid;
    assign b1.cfg_load = cfg_load;
    assign b1.cfg_pattern = cfg_pattern;
    assign b1.cfg_len = cfg_len;
    assign b1.cfg_overlap = cfg_overlap;
    assign b2.x = x;
    assign b2.x_valid = x_valid;
    assign b2.cfg_load = cfg_load;
    assign b2.cfg_pattern = cfg_pattern;
    assign b2.cfg_len = cfg_len;
    assign b2.cfg_overlap = cfg_overlap;

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    seq_detector_prog #(.MAX_LEN(8), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit mid-cycle and check the combinational flag of both instances.
    task automatic step(input logic xi, input logic vi, input logic ey, input string tag);
        @(negedge clk);
        cfg_load = 1'b0;
        x        = xi;
        x_valid  = vi;
        #1;
        chk(32'(b1.y), 32'(ey), {tag, "_y1"});
        chk(32'(b2.y), 32'(ey), {tag, "_y2"});
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                        input logic xi, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        x           = xi;
        x_valid     = 1'b1;
        #1;
        chk(32'(b1.y), 32'd0, {tag, "_y1"});
        chk(32'(b2.y), 32'd0, {tag, "_y2"});
    endtask

    initial begin
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Default configuration: legacy overlapping 1011 detector
        step(1'b0, 1'b0, 1'b0, "rst_idle");
        chk(32'(b1.armed), 32'd1, "rst_armed");
        chk(32'(b1.match_count), 32'd0, "rst_count");
        step(1'b1, 1'b1, 1'b0, "ov_b1");
        step(1'b0, 1'b1, 1'b0, "ov_b2");
        step(1'b1, 1'b1, 1'b0, "ov_b3");
        step(1'b1, 1'b1, 1'b1, "ov_b4");
        step(1'b0, 1'b1, 1'b0, "ov_b5");
        step(1'b1, 1'b1, 1'b0, "ov_b6");
        step(1'b1, 1'b1, 1'b1, "ov_b7");
        step(1'b0, 1'b0, 1'b0, "ov_idle");
        chk(32'(b1.match_count), 32'd2, "ov_count");

        // Non-overlapping 1011; the x=1 during load is discarded
        load(8'b1011, 4'd4, 1'b0, 1'b1, "ld_nov");
        step(1'b0, 1'b0, 1'b0, "nov_idle0");
        chk(32'(b1.match_count), 32'd0, "nov_clr_count");
        step(1'b1, 1'b1, 1'b0, "nov_b1");
        step(1'b0, 1'b1, 1'b0, "nov_b2");
        step(1'b1, 1'b1, 1'b0, "nov_b3");
        step(1'b1, 1'b1, 1'b1, "nov_b4");
        step(1'b0, 1'b1, 1'b0, "nov_b5");
        step(1'b1, 1'b1, 1'b0, "nov_b6");
        step(1'b1, 1'b1, 1'b0, "nov_b7");
        step(1'b0, 1'b0, 1'b0, "nov_idle");
        chk(32'(b1.match_count), 32'd1, "nov_count");

        // Full-length all-ones pattern with a gap of invalid cycles (x held 1)
        load(8'hFF, 4'd8, 1'b1, 1'b0, "ld_ff");
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b0, "ff_pre");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "ff_gap");
        step(1'b1, 1'b1, 1'b0, "ff_b6");
        step(1'b1, 1'b1, 1'b0, "ff_b7");
        step(1'b1, 1'b1, 1'b1, "ff_b8");
        step(1'b1, 1'b1, 1'b1, "ff_b9");
        step(1'b1, 1'b1, 1'b1, "ff_b10");
        step(1'b0, 1'b0, 1'b0, "ff_idle");
        chk(32'(b1.match_count), 32'd3, "ff_count");

        // History still all ones, so the first 1 matches again; then reset mid-sequence
        step(1'b1, 1'b1, 1'b1, "rs_b1");
        step(1'b0, 1'b1, 1'b0, "rs_b2");
        step(1'b1, 1'b1, 1'b0, "rs_b3");
        @(negedge clk);
        reset = 1'b1; cfg_load = 1'b1; x = 1'b1; x_valid = 1'b1;
        #1;
        chk(32'(b1.y), 32'd0, "rs_during_y");
        @(negedge clk);
        reset = 1'b0;
        cfg_load = 1'b0;
        #1;
        chk(32'(b1.y), 32'd0, "rs_after_y");
        chk(32'(b1.armed), 32'd1, "rs_armed");
        step(1'b0, 1'b0, 1'b0, "rs_idle");
        chk(32'(b1.match_count), 32'd0, "rs_count");

        // Length 0 disarms; history keeps shifting but never flags
        load(8'b1011, 4'd0, 1'b1, 1'b0, "ld_len0");
        step(1'b1, 1'b1, 1'b0, "l0_b1");
        chk(32'(b1.armed), 32'd0, "l0_armed");
        step(1'b0, 1'b1, 1'b0, "l0_b2");
        step(1'b1, 1'b1, 1'b0, "l0_b3");
        step(1'b1, 1'b1, 1'b0, "l0_b4");
        chk(32'(b1.match_count), 32'd0, "l0_count");
        load(8'b1011, 4'd9, 1'b1, 1'b0, "ld_len9");
        step(1'b0, 1'b0, 1'b0, "l9_idle");
        chk(32'(b1.armed), 32'd0, "l9_armed");
        load(8'b1011, 4'd4, 1'b1, 1'b0, "ld_len4");
        step(1'b1, 1'b1, 1'b0, "l4_b1");
        chk(32'(b1.armed), 32'd1, "l4_armed");
        step(1'b0, 1'b1, 1'b0, "l4_b2");
        step(1'b1, 1'b1, 1'b0, "l4_b3");
        step(1'b1, 1'b1, 1'b1, "l4_b4");

        // Length 1: upper pattern bits ignored, only pat[0]=1 matters
        load(8'hA5, 4'd1, 1'b0, 1'b0, "ld_len1");
        step(1'b1, 1'b1, 1'b1, "l1_b1");
        step(1'b0, 1'b1, 1'b0, "l1_b2");
        step(1'b1, 1'b1, 1'b1, "l1_b3");
        step(1'b1, 1'b0, 1'b0, "l1_gap");
        step(1'b0, 1'b0, 1'b0, "l1_idle");
        chk(32'(b1.match_count), 32'd2, "l1_count");

        // Counter saturation on the 2-bit instance
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b1, 1'b0, "sat_b1");
            step(1'b0, 1'b1, 1'b0, "sat_b2");
            step(1'b1, 1'b1, 1'b0, "sat_b3");
            step(1'b1, 1'b1, 1'b1, "sat_b4");
        end
        step(1'b0, 1'b0, 1'b0, "sat_idle");
        chk(32'(b2.match_count), 32'd3, "sat_count2");
        chk(32'(b1.match_count), 32'd5, "sat_count16");

        // Load collides with a completing bit: no flag, counters cleared
        step(1'b1, 1'b1, 1'b0, "col_b1");
        step(1'b0, 1'b1, 1'b0, "col_b2");
        step(1'b1, 1'b1, 1'b0, "col_b3");
        load(8'b1011, 4'd4, 1'b1, 1'b1, "col_ld");
        step(1'b0, 1'b0, 1'b0, "col_idle");
        chk(32'(b2.match_count), 32'd0, "col_count2");
        chk(32'(b1.match_count), 32'd0, "col_count16");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
